alu_stream_arbiter: RTL
=======================

# alu_stream_arbiter

Packet-level round-robin arbiter that shares the single byte-wide AXI-stream ALU between NUM_REQ requesters. It sits in front of the `alu` block. It grants one requester packet at a time, locked until `tlast`, and tags each beat with source ID and beat index on `m_axis_tuser_o`. Granted IDs go into a tag FIFO, and the ALU's response packets are routed back to the requester at the FIFO head.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters, 2..4.
- `TAG_DEPTH`, default 4: tag FIFO entries (power of two, ≥2), i.e. maximum packets outstanding in the ALU.

Ports (all widths in bits):
- `aclk_i`, input, 1: sole clock. All logic is on the rising edge.
- `rst_i`, input, 1: synchronous, active-high reset.
- `s_axis_tvalid_i`, input, NUM_REQ: per-requester valid.
- `s_axis_tready_o`, output, NUM_REQ: per-requester ready.
- `s_axis_tdata_i`, input, NUM_REQ*8: requester r's data on bits [8r+7:8r].
- `s_axis_tlast_i`, input, NUM_REQ: per-requester end of packet.
- `m_axis_tvalid_o`, output, 1: valid toward the ALU.
- `m_axis_tready_i`, input, 1: ready from the ALU.
- `m_axis_tdata_o`, output, 8: granted requester's data.
- `m_axis_tlast_o`, output, 1: granted requester's `tlast`.
- `m_axis_tuser_o`, output, 12: [1:0] is the source ID; [11:2] is the beat index within the packet.
- `r_axis_tvalid_i`, input, 1: ALU response valid.
- `r_axis_tready_o`, output, 1: ready toward the ALU response.
- `r_axis_tdata_i`, input, 8: ALU response data.
- `r_axis_tlast_i`, input, 1: ALU response end of packet.
- `d_axis_tvalid_o`, output, NUM_REQ: per-requester response valid.
- `d_axis_tready_i`, input, NUM_REQ: per-requester response ready.
- `d_axis_tdata_o`, output, 8: response data, broadcast to all requesters.
- `d_axis_tlast_o`, output, 1: response `tlast`, broadcast to all requesters.

## Operation
Request state machine has two states:
- **IDLE**
  - Enter when any `s_axis_tvalid_i` is set and the tag FIFO is not full.
  - Select the first valid requester in round-robin order, starting at `last_gnt+1` mod NUM_REQ.
  - Register it in `gnt`, push `gnt` into the tag FIFO, clear `beat_cnt`, and go to LOCK.
  - `m_axis_tvalid_o` is 0 and all `s_axis_tready_o` are 0 in IDLE.
- **LOCK**
  - Combinational pass-through: `m_axis_tvalid_o` = `s_axis_tvalid_i[gnt]`; `s_axis_tready_o[gnt]` = `m_axis_tready_i`; other ready bits are 0.
  - Data and `tlast` come from the granted requester.
  - `m_axis_tuser_o` = {`beat_cnt`, `gnt`}, with `gnt` zero-extended to 2 bits.
  - Each handshake increments `beat_cnt` (10 bits, saturates at 1023, no wrap).
  - A handshake with `tlast` set: `last_gnt`←`gnt`, go to IDLE.
  - The granted requester dropping valid mid-packet keeps the lock; no other requester may interleave.

Tag FIFO:
- Push happens only on the IDLE→LOCK transition.
- Pop happens on a response handshake with `r_axis_tlast_i` set.
- Simultaneous push and pop in one cycle is legal. Occupancy is unchanged and pointers wrap mod TAG_DEPTH.
- When full, no new grant is issued; a packet already in LOCK still completes.

Response routing (combinational on FIFO head `h`):
- FIFO not empty: `d_axis_tvalid_o[h]` = `r_axis_tvalid_i`, other valid bits are 0; `r_axis_tready_o` = `d_axis_tready_i[h]`.
- FIFO empty: all `d_axis_tvalid_o` = 0 and `r_axis_tready_o` = 0. A stray response stalls; it is never dropped.
- A response for the current packet may begin while that packet is still in LOCK, because its tag is already pushed.

Reset (`rst_i` = 1 at a clock edge):
- State←IDLE, `last_gnt`←NUM_REQ-1 (so requester 0 wins first), `gnt`←0, `beat_cnt`←0, FIFO pointers and count←0.
- Every output reads 0 while in reset and in the cycle after.
- Reset mid-packet aborts the lock and flushes tags. Downstream sees a truncated packet; this is accepted behaviour.

## Timing
- Grant latency is 1 cycle: valid seen in IDLE, first beat can transfer the next cycle.
- Packet gap is 1 IDLE cycle after every `tlast` beat. Back-to-back packets from anyone take N+1 cycles for N beats.
- Request data path and response path are zero-latency combinational pass-through with no registering.
- Full-throughput response: one beat per cycle while the head requester holds ready.
- No combinational path from `m_axis_tready_i` to `m_axis_tvalid_o`, nor from `d_axis_tready_i` to `d_axis_tvalid_o`.

## Test plan
- **Reset:** hold `rst_i` 3 cycles with all valids high.
  - All outputs must be 0 during reset and the cycle after.
  - Requester 0 is granted in the 2nd cycle after release.
- **Round-robin:** requesters 0 and 1 continuously send 3-beat packets, ALU always ready.
  - Grant order is 0,1,0,1.
  - `m_axis_tuser_o` = 0x000, 0x004, 0x008 for requester 0, and 0x001, 0x005, 0x009 for requester 1.
  - One idle cycle between packets.
- **Lock hold:** requester 1 drops valid for 4 cycles mid-packet while requester 0 is valid.
  - No requester 0 beat appears until requester 1's `tlast` beat.
- **FIFO full:** TAG_DEPTH=4, ALU response ready held 0, six 1-beat packets offered.
  - Exactly 4 grants, then `m_axis_tvalid_o` stays 0.
  - After one response `tlast` handshake, the 5th grant follows one cycle later.
- **Response routing:** grant order 1,0.
  - First response packet (2 beats) appears only on `d_axis_tvalid_o[1]`; second only on `d_axis_tvalid_o[0]`.
  - Deasserting `d_axis_tready_i[1]` forces `r_axis_tready_o` low.
  - A response arriving with the FIFO empty holds `r_axis_tready_o` = 0.
- **Reset mid-packet:** assert `rst_i` after beat 2 of 5.
  - FIFO empties and `m_axis_tvalid_o` goes low.
  - The next grant goes to requester 0 with `m_axis_tuser_o`[11:2] = 0.

Source files
------------

// File: rtl/alu_stream_arbiter.sv
// ============================================================================
// Module      : alu_stream_arbiter
// Description : Packet-level round-robin arbiter in front of the shared ALU,
//               with a tag FIFO that routes ALU responses back to requesters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_stream_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int TAG_DEPTH = 4
) (
  input  logic                 aclk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ-1:0]   s_axis_tvalid_i,
  output logic [NUM_REQ-1:0]   s_axis_tready_o,
  input  logic [NUM_REQ*8-1:0] s_axis_tdata_i,
  input  logic [NUM_REQ-1:0]   s_axis_tlast_i,
  output logic                 m_axis_tvalid_o,
  input  logic                 m_axis_tready_i,
  output logic [7:0]           m_axis_tdata_o,
  output logic                 m_axis_tlast_o,
  output logic [11:0]          m_axis_tuser_o,
  input  logic                 r_axis_tvalid_i,
  output logic                 r_axis_tready_o,
  input  logic [7:0]           r_axis_tdata_i,
  input  logic                 r_axis_tlast_i,
  output logic [NUM_REQ-1:0]   d_axis_tvalid_o,
  input  logic [NUM_REQ-1:0]   d_axis_tready_i,
  output logic [7:0]           d_axis_tdata_o,
  output logic                 d_axis_tlast_o
);

  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [1:0]    r_gnt;
  logic [1:0]    r_last_gnt;
  logic [9:0]    r_beat;
  logic [1:0]    r_tags [TAG_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic [1:0]    w_pick;
  logic          w_any;
  logic          w_sel_valid;
  logic          w_sel_last;
  logic [7:0]    w_sel_data;
  logic [1:0]    w_head;
  logic          w_head_ready;
  logic          w_lock;
  logic          w_has_tag;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_m_hs;

  // Round-robin pick: scanning offsets from farthest to nearest leaves the
  // nearest valid requester after last_gnt as the final assignment.
  always_comb begin
    w_pick = r_last_gnt;
    w_any  = 1'b0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (s_axis_tvalid_i[r] && (r == (int'(r_last_gnt) + i) % NUM_REQ)) begin
          w_pick = 2'(r);
          w_any  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_sel_valid  = 1'b0;
    w_sel_last   = 1'b0;
    w_sel_data   = 8'h00;
    w_head_ready = 1'b0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (r_gnt == 2'(r)) begin
        w_sel_valid = s_axis_tvalid_i[r];
        w_sel_last  = s_axis_tlast_i[r];
        w_sel_data  = s_axis_tdata_i[8*r +: 8];
      end
      if (w_head == 2'(r)) begin
        w_head_ready = d_axis_tready_i[r];
      end
    end
  end

  // Reset gates every output so nothing leaks while rst_i is held.
  assign w_lock    = (r_state == ST_LOCK) && !rst_i;
  assign w_has_tag = (r_count != '0) && !rst_i;
  assign w_full    = (r_count == CW'(TAG_DEPTH));
  assign w_head    = r_tags[r_rd_ptr];

  assign m_axis_tvalid_o = w_lock && w_sel_valid;
  assign m_axis_tdata_o  = w_lock ? w_sel_data : 8'h00;
  assign m_axis_tlast_o  = w_lock && w_sel_last;
  assign m_axis_tuser_o  = w_lock ? {r_beat, r_gnt} : 12'h000;
  assign w_m_hs          = m_axis_tvalid_o && m_axis_tready_i;

  assign r_axis_tready_o = w_has_tag && w_head_ready;
  assign d_axis_tdata_o  = w_has_tag ? r_axis_tdata_i : 8'h00;
  assign d_axis_tlast_o  = w_has_tag && r_axis_tlast_i;
  assign w_pop           = r_axis_tvalid_i && r_axis_tready_o && r_axis_tlast_i;

  always_comb begin
    s_axis_tready_o = '0;
    d_axis_tvalid_o = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      s_axis_tready_o[r] = w_lock && (r_gnt == 2'(r)) && m_axis_tready_i;
      d_axis_tvalid_o[r] = w_has_tag && (w_head == 2'(r)) && r_axis_tvalid_i;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any && !w_full) begin
          w_push      = 1'b1;
          w_state_nxt = ST_LOCK;
        end
      end
      ST_LOCK: begin
        if (w_m_hs && w_sel_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge aclk_i) begin
    if (rst_i) begin
      r_gnt      <= 2'b00;
      r_last_gnt <= 2'(NUM_REQ - 1);
      r_beat     <= 10'd0;
    end else if (w_push) begin
      r_gnt  <= w_pick;
      r_beat <= 10'd0;
    end else if (w_m_hs) begin
      if (r_beat != 10'h3FF) begin
        r_beat <= r_beat + 10'd1;
      end
      if (w_sel_last) begin
        r_last_gnt <= r_gnt;
      end
    end
  end

  always_ff @(posedge aclk_i) begin
    if (w_push && !rst_i) begin
      r_tags[r_wr_ptr] <= w_pick;
    end
  end

  always_ff @(posedge aclk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire
